// File: rtl/i2c_temp_master.sv
// Single-shot I2C master: writes the sensor config register, sets the temperature
// pointer, then reads one 16-bit sample and presents it on temp and led.
module i2c_temp_master #(
   parameter int         DVSR        = 250,
   parameter logic [6:0] SLAVE_ADDR  = 7'h4B,
   parameter logic [7:0] CONFIG_ADDR = 8'h01,
   parameter logic [7:0] CONFIG_DATA = 8'h60,
   parameter logic [7:0] TEMP_ADDR   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire         scl,
   inout  wire         sda,
   input  logic [3:0]  sw,
   output logic [3:0]  led,
   output logic [15:0] temp,
   output logic        valid,
   output logic        ack_err
);
   localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

   typedef enum logic [3:0] {
      IDLE, START, TXBYTE, TXACK, RXBYTE, RXACK, STOP, GAP, DONE
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] tick_cnt;
   logic [1:0]    phase;
   logic [2:0]    bit_cnt;
   logic [1:0]    txn, byte_idx;
   logic [7:0]    shreg, byte1, tx_byte;
   logic          sda_smp, scl_q, sda_q, scl_drv, sda_drv;
   logic          tick, phase_end, last_tx, scl_bit_low;

   assign tick        = (tick_cnt == CW'(DVSR - 1));
   assign phase_end   = tick && (phase == 2'd3);
   assign scl_bit_low = (phase == 2'd0) || (phase == 2'd3);

   // Byte schedule: transaction number and byte index select what goes on the wire.
   always_comb begin
      case ({txn, byte_idx})
         4'b00_00, 4'b01_00: tx_byte = {SLAVE_ADDR, 1'b0};
         4'b00_01:           tx_byte = CONFIG_ADDR;
         4'b00_10:           tx_byte = CONFIG_DATA;
         4'b01_01:           tx_byte = TEMP_ADDR;
         default:            tx_byte = {SLAVE_ADDR, 1'b1};
      endcase
   end

   assign last_tx = ({txn, byte_idx} == 4'b00_10) || ({txn, byte_idx} == 4'b01_01);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      scl_drv    = 1'b0;
      sda_drv    = 1'b0;
      case (state)
         IDLE:   if (tick) state_next = START;
         START: begin
            sda_drv = (phase != 2'd0);
            scl_drv = phase[1];
            if (phase_end) state_next = TXBYTE;
         end
         TXBYTE: begin
            scl_drv = scl_bit_low;
            sda_drv = ~tx_byte[bit_cnt];
            if (phase_end && bit_cnt == 3'd0) state_next = TXACK;
         end
         TXACK: begin
            scl_drv = scl_bit_low;
            if (phase_end) begin
               if (sda_smp)          state_next = STOP;
               else if (txn == 2'd2) state_next = RXBYTE;
               else if (last_tx)     state_next = STOP;
               else                  state_next = TXBYTE;
            end
         end
         RXBYTE: begin
            scl_drv = scl_bit_low;
            if (phase_end && bit_cnt == 3'd0) state_next = RXACK;
         end
         RXACK: begin
            scl_drv = scl_bit_low;
            sda_drv = (byte_idx == 2'd0);
            if (phase_end) state_next = (byte_idx == 2'd0) ? RXBYTE : STOP;
         end
         STOP: begin
            scl_drv = (phase == 2'd0);
            sda_drv = ~phase[1];
            if (phase_end) state_next = (ack_err || txn == 2'd2) ? DONE : GAP;
         end
         GAP:    if (phase_end) state_next = START;
         DONE:   state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         phase    <= 2'd0;
         bit_cnt  <= 3'd7;
         txn      <= 2'd0;
         byte_idx <= 2'd0;
         shreg    <= 8'h00;
         byte1    <= 8'h00;
         sda_smp  <= 1'b1;
         scl_q    <= 1'b0;
         sda_q    <= 1'b0;
         temp     <= 16'h0000;
         valid    <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick && state != IDLE && state != DONE) phase <= phase + 2'd1;
         if (tick && phase == 2'd2) begin
            sda_smp <= sda;
            if (state == RXBYTE) shreg <= {shreg[6:0], sda};
         end
         // 3-bit down counter wraps 0 -> 7, so it is already 7 at every byte start.
         if (phase_end && (state == TXBYTE || state == RXBYTE)) bit_cnt <= bit_cnt - 3'd1;
         if (phase_end) begin
            case (state)
               TXACK: begin
                  if (sda_smp) ack_err <= 1'b1;
                  else if (txn != 2'd2 && !last_tx) byte_idx <= byte_idx + 2'd1;
               end
               RXACK: if (byte_idx == 2'd0) begin
                  byte1    <= shreg;
                  byte_idx <= 2'd1;
               end
               STOP: if (!ack_err) begin
                  if (txn == 2'd2) begin
                     temp  <= {byte1, shreg};
                     valid <= 1'b1;
                  end else begin
                     txn <= txn + 2'd1;
                  end
               end
               GAP: byte_idx <= 2'd0;
               default: ;
            endcase
         end
         // Registered enables keep the open-drain pins free of decode glitches.
         scl_q <= scl_drv;
         sda_q <= sda_drv;
      end
   end

   assign scl = scl_q ? 1'b0 : 1'bz;
   assign sda = sda_q ? 1'b0 : 1'bz;

   always_comb begin
      case (sw)
         4'h8:    led = temp[15:12];
         4'h4:    led = temp[11:8];
         4'h2:    led = temp[7:4];
         4'h1:    led = temp[3:0];
         default: led = 4'h0;
      endcase
   end
endmodule

// File: tb/tb_i2c_temp_master.sv
// Bench for i2c_temp_master: behavioural I2C slave, bus-event scoreboard fed by a
// transaction-level reference model, and randomized slave data / NACK placement.
module tb_i2c_temp_master;
   localparam int DVSR = 4;
   localparam int EV_START = 256, EV_STOP = 257, EV_ACK = 258, EV_NACK = 259;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  sw  = 4'h0;
   wire  [3:0]  led;
   wire  [15:0] temp;
   wire         valid, ack_err;
   wire         scl_b, sda_b;
   logic        slv_sda_low = 1'b0;

   pullup (scl_b);
   pullup (sda_b);
   assign sda_b = slv_sda_low ? 1'b0 : 1'bz;

   i2c_temp_master #(.DVSR(DVSR)) dut (
      .clk(clk), .rst(rst), .scl(scl_b), .sda(sda_b), .sw(sw),
      .led(led), .temp(temp), .valid(valid), .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0;
   int          nack_at = -1;
   logic [15:0] rd_data = 16'h0;
   int          exp_q[$];
   logic [15:0] res_q[$];
   int          events_seen = 0;
   logic        exp_valid, exp_err;
   logic [15:0] exp_temp;
   logic [7:0]  tx_tab [3][3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic emit(input int ev);
      events_seen++;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL bus_event: got %0d, expected no further bus activity", ev);
      end else begin
         check("bus_event", ev, exp_q.pop_front());
      end
   endtask

   // Reference model: three transactions, slave write-byte acks counted in bus order.
   task automatic build_expected(input int nack, input logic [15:0] rd);
      int w = 0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_temp  = 16'h0;
      for (int t = 0; t < 3; t++) begin
         int nbytes = (t == 0) ? 3 : (t == 1) ? 2 : 1;
         exp_q.push_back(EV_START);
         for (int b = 0; b < nbytes; b++) begin
            exp_q.push_back(int'(tx_tab[t][b]));
            if (w == nack) begin
               exp_q.push_back(EV_NACK);
               exp_q.push_back(EV_STOP);
               exp_err = 1'b1;
               return;
            end
            exp_q.push_back(EV_ACK);
            w++;
         end
         if (t == 2) begin
            exp_q.push_back(int'(rd[15:8]));
            exp_q.push_back(EV_ACK);
            exp_q.push_back(int'(rd[7:0]));
            exp_q.push_back(EV_NACK);
            res_q.push_back(rd);
            exp_valid = 1'b1;
            exp_temp  = rd;
         end
         exp_q.push_back(EV_STOP);
      end
   endtask

   // Behavioural slave: ACKs writes unless told to NACK one, returns rd_data on reads.
   initial begin
      logic s, d, ps, pd, in_txn, rw, ack_seen;
      logic [7:0] sh, rb;
      int bit_n, byte_n, wr_idx, rd_idx;
      ps = 1'b1; pd = 1'b1; in_txn = 1'b0; rw = 1'b0; ack_seen = 1'b1;
      sh = 8'h0; rb = 8'h0; bit_n = 0; byte_n = 0; wr_idx = 0; rd_idx = 0;
      forever begin
         @(negedge clk);
         s = scl_b;
         d = sda_b;
         if (!rst) begin
            in_txn = 1'b0; slv_sda_low = 1'b0; wr_idx = 0; rd_idx = 0;
            ps = 1'b1; pd = 1'b1;
         end else begin
            if (s && ps && pd && !d) begin
               in_txn = 1'b1; bit_n = 0; byte_n = 0; rw = 1'b0;
            end else if (s && ps && !pd && d) begin
               in_txn = 1'b0; slv_sda_low = 1'b0;
            end else if (in_txn && !ps && s) begin
               if (bit_n < 8) sh = {sh[6:0], d};
               else           ack_seen = d;
               bit_n++;
            end else if (in_txn && ps && !s) begin
               if (bit_n == 8) begin
                  if (byte_n == 0 || !rw) begin
                     if (byte_n == 0) rw = sh[0];
                     slv_sda_low = (wr_idx != nack_at);
                     wr_idx++;
                  end else begin
                     slv_sda_low = 1'b0;
                  end
               end else if (bit_n == 9) begin
                  bit_n = 0;
                  byte_n++;
                  slv_sda_low = 1'b0;
                  if (rw && !ack_seen) begin
                     rb = (rd_idx == 0) ? rd_data[15:8] : rd_data[7:0];
                     rd_idx++;
                     slv_sda_low = !rb[7];
                  end
               end else if (rw && byte_n >= 1 && bit_n >= 1 && bit_n <= 7) begin
                  slv_sda_low = !rb[7 - bit_n];
               end
            end
            ps = s;
            pd = d;
         end
      end
   end

   // Bus monitor: decodes START/STOP/bytes/acks and checks scl high time and START hold.
   initial begin
      logic s, d, ps, pd, meas, st_meas;
      logic [7:0] sh;
      int cnt, hi, since;
      ps = 1'b1; pd = 1'b1; meas = 1'b0; st_meas = 1'b0; sh = 8'h0;
      cnt = 0; hi = 0; since = 0;
      forever begin
         @(negedge clk);
         s = scl_b;
         d = sda_b;
         if (!rst) begin
            ps = 1'b1; pd = 1'b1; cnt = 0; meas = 1'b0; st_meas = 1'b0;
         end else begin
            if (s && ps && pd && !d) begin
               emit(EV_START);
               cnt = 0; meas = 1'b0; st_meas = 1'b1; since = 1;
            end else if (s && ps && !pd && d) begin
               emit(EV_STOP);
               meas = 1'b0; st_meas = 1'b0;
            end else if (!ps && s) begin
               sh = {sh[6:0], d};
               cnt++;
               if (cnt == 8) emit(int'(sh));
               else if (cnt == 9) begin
                  emit(d ? EV_NACK : EV_ACK);
                  cnt = 0;
               end
               meas = 1'b1;
               hi = 1;
            end else if (ps && !s) begin
               if (meas)    check("scl_high_time", hi, 2 * DVSR);
               if (st_meas) check("start_hold", (since >= DVSR) ? 1 : 0, 1);
               meas = 1'b0; st_meas = 1'b0;
            end else if (s) begin
               if (meas) hi++;
               if (st_meas) since++;
            end
            ps = s;
            pd = d;
         end
      end
   end

   // Result monitor: temp must carry the expected sample in the cycle valid rises.
   initial begin
      logic seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) seen = 1'b0;
         else if (valid && !seen) begin
            seen = 1'b1;
            if (res_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL valid_rise: got temp %0h with valid, expected no result", temp);
            end else begin
               check("temp_at_valid", temp, res_q.pop_front());
            end
         end
      end
   end

   task automatic start_scn(input int nack, input logic [15:0] rd);
      @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      res_q.delete();
      events_seen = 0;
      nack_at = nack;
      rd_data = rd;
      build_expected(nack, rd);
      repeat (3) @(posedge clk);
      #2;
      check("rst_temp", temp, 16'h0);
      check("rst_valid", valid, 1'b0);
      check("rst_ack_err", ack_err, 1'b0);
      check("rst_bus", {scl_b, sda_b}, 2'b11);
      rst = 1'b1;
   endtask

   task automatic finish_scn();
      int cyc = 0;
      while (!(valid || ack_err) && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      check("done_in_time", (cyc < 5000) ? 1 : 0, 1);
      repeat (300) @(posedge clk);
      #2;
      check("events_left", exp_q.size(), 0);
      check("results_left", res_q.size(), 0);
      check("final_temp", temp, exp_temp);
      check("final_valid", valid, exp_valid);
      check("final_ack_err", ack_err, exp_err);
      check("final_bus", {scl_b, sda_b}, 2'b11);
   endtask

   task automatic run_scn(input int nack, input logic [15:0] rd);
      start_scn(nack, rd);
      finish_scn();
   endtask

   initial begin
      logic [15:0] rd;
      int nk;
      int cyc;
      tx_tab[0][0] = 8'h96; tx_tab[0][1] = 8'h01; tx_tab[0][2] = 8'h60;
      tx_tab[1][0] = 8'h96; tx_tab[1][1] = 8'h00; tx_tab[1][2] = 8'h00;
      tx_tab[2][0] = 8'h97; tx_tab[2][1] = 8'h00; tx_tab[2][2] = 8'h00;

      run_scn(-1, 16'h1234);
      sw = 4'h8; #1 check("led_sw8", led, 4'h1);
      sw = 4'h4; #1 check("led_sw4", led, 4'h2);
      sw = 4'h2; #1 check("led_sw2", led, 4'h3);
      sw = 4'h1; #1 check("led_sw1", led, 4'h4);
      sw = 4'h0; #1 check("led_sw0", led, 4'h0);
      sw = 4'h3; #1 check("led_sw3", led, 4'h0);
      sw = 4'h0;

      run_scn(0, 16'h1111);
      run_scn(2, 16'h2222);

      // Abort in the middle of transaction 2's second byte, then re-run cleanly.
      start_scn(-1, 16'h5555);
      cyc = 0;
      while (events_seen < 11 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      check("reach_txn2_byte2", (cyc < 3000) ? 1 : 0, 1);
      repeat (40) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_bus", {scl_b, sda_b}, 2'b11);
      check("abort_valid", valid, 1'b0);
      run_scn(-1, 16'hABCD);

      for (int i = 0; i < 6; i++) begin
         rd = 16'($urandom);
         nk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         run_scn(nk, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
